fifo_rr_write_arbiter: RTL and testbench

//  Shares one synchronous FIFO write port among NUM_REQ producers.
//  - Arbitration: round-robin with bounded bursts.
//  - Producer side: valid/ready handshake per requester.
//  - FIFO side: drives WR_EN/DATA_IN and honours FIFO FULL.
//  - Sits between the producer blocks and the FIFO write interface.

---
 rtl/fifo_arb_pkg.sv | 29 ++
 rtl/rr_priority_picker.sv | 40 ++++
 rtl/fifo_rr_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_rr_write_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : fifo_arb_pkg                                                   |
// | Purpose   : Shared types and width helpers for the round-robin FIFO write  |
// |             arbiter and its priority picker.                               |
// | Contents  : arb_state_t   - arbiter FSM states (IDLE, BURST)               |
// |             idx_width()   - index width for N items, minimum 1 bit         |
// |             cnt_width()   - counter width able to hold 0..max inclusive    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of an index selecting one of n items; a single item still needs a wire.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must represent every value 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : rr_priority_picker                                             |
// | Purpose   : Combinational rotating priority encoder. Scans the request     |
// |             vector starting one past the previous grant and returns the    |
// |             first active requester, wrapping modulo NUM_REQ.               |
// | Ports     : req        in  NUM_REQ  active requests                        |
// |             last_grant in  IDX_W    index of the most recent grant         |
// |             grant      out IDX_W    winning index (0 when no request)      |
// |             any_req    out 1        at least one request is active         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] w_cand;

  // Walk candidates from farthest (last_grant+NUM_REQ == last_grant) down to
  // nearest (last_grant+1); the last hit written is the highest-priority one.
  always_comb begin
    grant   = '0;
    w_cand  = '0;
    any_req = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[w_cand]) begin
        grant = w_cand;
      end
    end
  end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/fifo_rr_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fifo_rr_write_arbiter                                          |
// | Purpose   : Shares one synchronous FIFO write port among NUM_REQ producers |
// |             with round-robin arbitration and bursts of at most MAX_BURST   |
// |             beats per grant. Handshake to FIFO write has zero latency.     |
// | Ports     : FCLK          in  1                 clock, rising edge         |
// |             FRSTN         in  1                 async reset, active low    |
// |             REQ_VALID     in  NUM_REQ           per-requester valid        |
// |             REQ_DATA      in  NUM_REQ*DATA_W    packed payloads            |
// |             REQ_READY     out NUM_REQ           per-requester accept       |
// |             FIFO_FULL     in  1                 FIFO full flag             |
// |             FIFO_WR_EN    out 1                 FIFO write enable          |
// |             FIFO_DATA_IN  out DATA_WIDTH        FIFO write data            |
// |             GRANT_ID      out idx_width(NUM_REQ) current owner index       |
// |             BUSY          out 1                 a grant is held            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            FCLK,
  input  logic                            FRSTN,
  input  logic [NUM_REQ-1:0]              REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]              REQ_READY,
  input  logic                            FIFO_FULL,
  output logic                            FIFO_WR_EN,
  output logic [DATA_WIDTH-1:0]           FIFO_DATA_IN,
  output logic [idx_width(NUM_REQ)-1:0]   GRANT_ID,
  output logic                            BUSY
);

  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int BEAT_W = cnt_width(MAX_BURST);
  localparam logic [BEAT_W-1:0] C_MAX_BEAT  = BEAT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]  C_LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_t        r_state,      w_state_nxt;
  logic [IDX_W-1:0]  r_owner,      w_owner_nxt;
  logic [IDX_W-1:0]  r_last_grant, w_last_grant_nxt;
  logic [BEAT_W-1:0] r_beat_cnt,   w_beat_cnt_nxt;

  logic [IDX_W-1:0]      w_pick;
  logic                  w_any_req;
  logic                  w_busy;
  logic                  w_owner_valid;
  logic                  w_xfer;
  logic [BEAT_W-1:0]     w_beat_inc;
  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (REQ_VALID),
    .last_grant (r_last_grant),
    .grant      (w_pick),
    .any_req    (w_any_req)
  );

  // Unpack the payload bus so the owner's slice is a plain array lookup.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign w_slice[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_busy        = (r_state == BURST);
  assign w_owner_valid = REQ_VALID[r_owner];
  assign w_xfer        = w_busy && w_owner_valid && !FIFO_FULL;
  assign w_beat_inc    = r_beat_cnt + BEAT_W'(1);

  // READY is one-hot on the owner, or all-zero when idle or stalled by FULL.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
      assign REQ_READY[i] = w_busy && !FIFO_FULL && (r_owner == IDX_W'(i));
    end
  endgenerate

  assign FIFO_WR_EN   = |(REQ_VALID & REQ_READY);
  assign FIFO_DATA_IN = w_busy ? w_slice[r_owner] : '0;
  assign GRANT_ID     = r_owner;
  assign BUSY         = w_busy;

  always_ff @(posedge FCLK or negedge FRSTN) begin
    if (!FRSTN) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_grant <= C_LAST_INIT;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        // Granting takes this whole cycle; the first beat moves next cycle.
        if (w_any_req) begin
          w_state_nxt      = BURST;
          w_owner_nxt      = w_pick;
          w_last_grant_nxt = w_pick;
          w_beat_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (!w_owner_valid) begin
          // Owner withdrew: release regardless of FULL so others can proceed.
          w_state_nxt    = IDLE;
          w_beat_cnt_nxt = '0;
        end else if (w_xfer) begin
          if (w_beat_inc == C_MAX_BEAT) begin
            w_state_nxt    = IDLE;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = w_beat_inc;
          end
        end
        // Owner valid but FIFO full: hold everything, no timeout.
      end
      default: begin
        w_state_nxt    = IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

endmodule : fifo_rr_write_arbiter
`default_nettype wire

// File: tb/tb_fifo_rr_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_fifo_rr_write_arbiter                                       |
// | Purpose   : Self-checking bench for fifo_rr_write_arbiter. Producers are   |
// |             modelled as payload queues; a behavioural arbiter model        |
// |             predicts READY, WR_EN, data, GRANT_ID and BUSY every cycle.    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fifo_rr_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            FCLK = 1'b0;
  logic            FRSTN;
  logic [N-1:0]    REQ_VALID;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_READY;
  logic            FIFO_FULL;
  logic            FIFO_WR_EN;
  logic [DW-1:0]   FIFO_DATA_IN;
  logic [1:0]      GRANT_ID;
  logic            BUSY;

  always #5 FCLK = ~FCLK;

  fifo_rr_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .FCLK         (FCLK),
    .FRSTN        (FRSTN),
    .REQ_VALID    (REQ_VALID),
    .REQ_DATA     (REQ_DATA),
    .REQ_READY    (REQ_READY),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WR_EN   (FIFO_WR_EN),
    .FIFO_DATA_IN (FIFO_DATA_IN),
    .GRANT_ID     (GRANT_ID),
    .BUSY         (BUSY)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Producer side: pending payloads per requester, plus a per-cycle enable
  // that lets a producer withdraw VALID while keeping its head payload.
  logic [DW-1:0] pend [N][$];
  bit            en   [N];
  bit            full_r;

  // Arbiter reference model.
  int m_busy, m_owner, m_beats, m_last;

  logic [DW-1:0] dut_q [$];
  int            gq    [$];
  bit            prev_busy;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ_VALID[i]           = en[i] && (pend[i].size() > 0);
      REQ_DATA[i*DW +: DW]   = (pend[i].size() > 0) ? pend[i][0] : '0;
    end
    FIFO_FULL = full_r;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_last = N - 1;
    prev_busy = 0;
  endtask

  // One clock cycle, entered just after a falling edge.
  task automatic cycle();
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] exp_data;
    bit            xfer;
    bit            found;
    int            o;
    drive();
    #1;
    exp_ready = (m_busy != 0 && !full_r) ? (N'(1) << m_owner) : '0;
    exp_data  = (m_busy != 0) ? REQ_DATA[m_owner*DW +: DW] : '0;
    xfer      = (m_busy != 0) && !full_r && REQ_VALID[m_owner];
    check("ready",  32'(REQ_READY),    32'(exp_ready));
    check("wr_en",  32'(FIFO_WR_EN),   32'(xfer));
    check("data",   32'(FIFO_DATA_IN), 32'(exp_data));
    check("grant",  32'(GRANT_ID),     32'(m_owner));
    check("busy",   32'(BUSY),         32'(m_busy));
    if (FIFO_WR_EN === 1'b1) dut_q.push_back(FIFO_DATA_IN);
    if (BUSY === 1'b1 && !prev_busy) gq.push_back(int'(GRANT_ID));
    prev_busy = (BUSY === 1'b1);
    o = m_owner;
    if (m_busy == 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && REQ_VALID[(m_last + k) % N]) begin
          found   = 1;
          m_owner = (m_last + k) % N;
          m_last  = m_owner;
          m_beats = 0;
          m_busy  = 1;
        end
      end
    end else if (!REQ_VALID[m_owner]) begin
      m_busy = 0; m_beats = 0;
    end else if (!full_r) begin
      m_beats++;
      if (m_beats == MB) begin
        m_busy = 0; m_beats = 0;
      end
    end
    if (xfer) void'(pend[o].pop_front());
    @(negedge FCLK);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic reset_now();
    #2 FRSTN = 1'b0;
    #1;
    check("rst_ready", 32'(REQ_READY),    32'd0);
    check("rst_wr_en", 32'(FIFO_WR_EN),   32'd0);
    check("rst_busy",  32'(BUSY),         32'd0);
    check("rst_grant", 32'(GRANT_ID),     32'd0);
    check("rst_data",  32'(FIFO_DATA_IN), 32'd0);
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      en[i] = 1'b1;
    end
    full_r = 1'b0;
    drive();
    model_reset();
    @(negedge FCLK);
    @(negedge FCLK);
    FRSTN = 1'b1;
  endtask

  initial begin
    FRSTN = 1'b1;
    full_r = 1'b0;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    model_reset();
    drive();
    @(negedge FCLK);
    reset_now();

    // Sole requester 1 with four beats: one bubble, then four writes.
    pend[1].push_back(8'hA1); pend[1].push_back(8'hA2);
    pend[1].push_back(8'hA3); pend[1].push_back(8'hA4);
    dut_q.delete(); gq.delete();
    repeat (7) cycle();
    check("t1_nwrites", 32'(dut_q.size()), 32'd4);
    if (dut_q.size() == 4) begin
      check("t1_beat0", 32'(dut_q[0]), 32'hA1);
      check("t1_beat1", 32'(dut_q[1]), 32'hA2);
      check("t1_beat2", 32'(dut_q[2]), 32'hA3);
      check("t1_beat3", 32'(dut_q[3]), 32'hA4);
    end
    check("t1_ngrants", 32'(gq.size()), 32'd1);
    if (gq.size() >= 1) check("t1_owner", 32'(gq[0]), 32'd1);

    // last_grant is now 1; requesters 0 and 2 valid -> 2 first, then 0.
    pend[0].push_back(8'hB0);
    pend[2].push_back(8'hB2);
    gq.delete();
    repeat (6) cycle();
    check("t5_ngrants", 32'(gq.size()), 32'd2);
    if (gq.size() >= 2) begin
      check("t5_first",  32'(gq[0]), 32'd2);
      check("t5_second", 32'(gq[1]), 32'd0);
    end

    // Reset in the middle of a burst, then every requester valid.
    for (int j = 0; j < 4; j++) pend[3].push_back(8'(8'hC0 + j));
    repeat (2) cycle();
    reset_now();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) pend[i].push_back(8'(i * 16 + j));
    gq.delete();
    repeat (30) cycle();
    check("t2_ngrants", 32'(gq.size() >= 5), 32'd1);
    if (gq.size() >= 5) begin
      check("t2_g0", 32'(gq[0]), 32'd0);
      check("t2_g1", 32'(gq[1]), 32'd1);
      check("t2_g2", 32'(gq[2]), 32'd2);
      check("t2_g3", 32'(gq[3]), 32'd3);
      check("t2_g4", 32'(gq[4]), 32'd0);
    end

    // Randomised traffic: sporadic payloads, VALID withdrawals, FIFO full.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i].size() < 3 && $urandom_range(0, 3) == 0)
          pend[i].push_back(8'($urandom));
        en[i] = ($urandom_range(0, 7) != 0);
      end
      full_r = ($urandom_range(0, 3) == 0);
      cycle();
    end

    // Drain: every pending beat must eventually be written.
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    full_r = 1'b0;
    repeat (80) cycle();
    check("drain", 32'(pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fifo_rr_write_arbiter
`default_nettype wire
